ripple_count_capture: RTL and testbench

- Downstream consumer of the 4-bit asynchronous ripple up-counter (D-flip-flop stages, active-low clear).
- Synchronises the counter's rippling, glitch-prone `count` bus into the `Clk` domain.
- Accepts a value only once it has been stable for a set number of cycles.
- Extends the count with a wrap counter and hands timestamped snapshots to a consumer over a valid/ready handshake.

---
 rtl/ripple_capture_pkg.sv | 17 +
 rtl/sync_2ff.sv | 31 +++
 rtl/ripple_count_capture.sv | 140 ++++++++++++++
 tb/tb_ripple_count_capture.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ripple_capture_pkg.sv
// ripple_capture_pkg
//   Shared constants for ripple_count_capture: default bus widths, the
//   stability-filter depth, the stab_cnt width and the capture FSM encodings.
//   No ports.
package ripple_capture_pkg;

  localparam int CNT_W_DEF    = 4;
  localparam int EXT_W_DEF    = 4;
  localparam int STABLE_N_DEF = 2;

  // Wide enough for the largest legal STABLE_N (7).
  localparam int STAB_W = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for a bus that is asynchronous to clk. Each bit
//   is synchronised on its own, so the bus can still show mixed old/new
//   values for a cycle; the downstream stability filter deals with that.
// Ports:
//   clk    in   sampling clock, rising edge
//   rst_n  in   asynchronous active-low clear
//   d      in   [W]  asynchronous input bus
//   q      out  [W]  synchronised bus (second flop)
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/ripple_count_capture.sv
// ripple_count_capture
//   Brings a 4-bit asynchronous ripple-counter bus into the Clk domain,
//   accepts a value only after STABLE_N equal consecutive samples, extends
//   it with a wrap counter and hands {ext, acc} snapshots to a consumer over
//   a valid/ready handshake.
// Ports:
//   Clk          in   system clock, rising edge
//   ClrN         in   asynchronous active-low reset
//   count_in     in   [CNT_W] ripple-counter output, asynchronous to Clk
//   capture_req  in   single-cycle snapshot request
//   value_out    out  [EXT_W+CNT_W] snapshot {ext, acc}
//   value_valid  out  snapshot held, waiting for value_ready
//   value_ready  in   consumer accepts the snapshot
//   wrap_pulse   out  one-cycle pulse when a wrap is detected
//   overrun      out  (RIPPLE_CAPTURE_OVERRUN_EN only) sticky flag, set when
//                     a capture_req is dropped in HOLD, cleared by the next
//                     completed handshake
// Optional feature macro: RIPPLE_CAPTURE_OVERRUN_EN
//
// Capture FSM:
//   state | meaning
//   IDLE  | no snapshot outstanding, waiting for capture_req
//   HOLD  | snapshot presented on value_out, waiting for value_ready
module ripple_count_capture
  import ripple_capture_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int EXT_W    = EXT_W_DEF,
  parameter int STABLE_N = STABLE_N_DEF   // legal range 1..7
) (
  input  logic                   Clk,
  input  logic                   ClrN,
  input  logic [CNT_W-1:0]       count_in,
  input  logic                   capture_req,
  output logic [EXT_W+CNT_W-1:0] value_out,
  output logic                   value_valid,
  input  logic                   value_ready,
  output logic                   wrap_pulse
`ifdef RIPPLE_CAPTURE_OVERRUN_EN
  ,
  output logic                   overrun
`endif
);

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_N);

  logic [CNT_W-1:0]  sync2;
  logic [CNT_W-1:0]  prev;
  logic [STAB_W-1:0] stab_cnt;
  logic [STAB_W-1:0] stab_nxt;
  logic [CNT_W-1:0]  acc;
  logic [EXT_W-1:0]  ext;
  logic [0:0]        state;
  logic              acc_load;
  logic              acc_dec;

  sync_2ff #(
    .W (CNT_W)
  ) u_sync (
    .clk   (Clk),
    .rst_n (ClrN),
    .d     (count_in),
    .q     (sync2)
  );

  // The accept decision uses the post-edge stab_cnt value so that a value
  // settled before edge k is loaded into acc on edge k+1+STABLE_N.
  always_comb begin
    stab_nxt = stab_cnt;
    if (sync2 != prev) begin
      stab_nxt = STAB_W'(1);
    end else if (stab_cnt < STAB_MAX) begin
      stab_nxt = stab_cnt + 1'b1;
    end
  end

  assign acc_load = (stab_nxt == STAB_MAX) && (sync2 != acc);
  // Any numeric decrease, including a counter clear, is treated as a wrap.
  assign acc_dec  = acc_load && (sync2 < acc);

  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      prev       <= '0;
      stab_cnt   <= '0;
      acc        <= '0;
      ext        <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      prev       <= sync2;
      stab_cnt   <= stab_nxt;
      wrap_pulse <= acc_dec;
      if (acc_load) begin
        acc <= sync2;
      end
      if (acc_dec) begin
        ext <= ext + 1'b1;
      end
    end
  end

  // {ext, acc} are sampled as registers, so a same-cycle acc/ext update
  // (including a wrap) is not seen by the snapshot.
  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      state       <= ST_IDLE;
      value_out   <= '0;
      value_valid <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (capture_req) begin
        value_out   <= {ext, acc};
        value_valid <= 1'b1;
        state       <= ST_HOLD;
      end
    end else begin
      if (value_ready) begin
        if (capture_req) begin
          value_out <= {ext, acc};
        end else begin
          value_valid <= 1'b0;
          state       <= ST_IDLE;
        end
      end
    end
  end

`ifdef RIPPLE_CAPTURE_OVERRUN_EN
  // Set and clear cannot coincide: in HOLD value_valid is 1, so a handshake
  // requires value_ready, which excludes the set condition.
  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      overrun <= 1'b0;
    end else if ((state == ST_HOLD) && capture_req && !value_ready) begin
      overrun <= 1'b1;
    end else if (value_valid && value_ready) begin
      overrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ripple_count_capture.sv
// tb_ripple_count_capture
//   Directed bench for ripple_count_capture with STABLE_N=2. Inputs change
//   on the falling edge; outputs are checked on the falling edge.
module tb_ripple_count_capture;

  logic       Clk;
  logic       ClrN;
  logic [3:0] count_in;
  logic       capture_req;
  logic [7:0] value_out;
  logic       value_valid;
  logic       value_ready;
  logic       wrap_pulse;
`ifdef RIPPLE_CAPTURE_OVERRUN_EN
  logic       overrun;
`endif

  int checks = 0;
  int errors = 0;
  int wrap_cnt = 0;
  bit saw7 = 1'b0;

  ripple_count_capture dut (
    .Clk         (Clk),
    .ClrN        (ClrN),
    .count_in    (count_in),
    .capture_req (capture_req),
    .value_out   (value_out),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .wrap_pulse  (wrap_pulse)
`ifdef RIPPLE_CAPTURE_OVERRUN_EN
    ,
    .overrun     (overrun)
`endif
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (wrap_pulse) wrap_cnt++;
    if (dut.acc == 4'd7) saw7 = 1'b1;
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_capture();
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ClrN        = 1'b0;
    count_in    = 4'd0;
    capture_req = 1'b0;
    value_ready = 1'b0;

    // Reset held for 45 ns, released on a falling edge.
    #20;
    check_val("rst_valid", 16'(value_valid), 16'd0);
    check_val("rst_wrap", 16'(wrap_pulse), 16'd0);
    check_val("rst_value", 16'(value_out), 16'h00);
    repeat (3) @(negedge Clk);
    ClrN = 1'b1;
    tick();
    check_val("post_rst_valid", 16'(value_valid), 16'd0);
    check_val("post_rst_acc", 16'(dut.acc), 16'd0);

    // Step 0 -> 1: acc must change exactly on the third edge.
    count_in = 4'd1;
    tick(3);
    check_val("lat_acc_k2", 16'(dut.acc), 16'd0);
    tick();
    check_val("lat_acc_k3", 16'(dut.acc), 16'd1);
    check_val("lat_valid", 16'(value_valid), 16'd0);
    check_val("lat_wrap", 16'(wrap_pulse), 16'd0);

    // Glitch rejection.
    count_in = 4'd3;
    tick(6);
    check_val("glitch_pre_acc", 16'(dut.acc), 16'd3);
    count_in = 4'd7;
    tick();
    count_in = 4'd3;
    tick();
    count_in = 4'd4;
    tick(6);
    check_val("glitch_no7", 16'(saw7), 16'd0);
    check_val("glitch_acc", 16'(dut.acc), 16'd4);
    check_val("glitch_nowrap", 16'(wrap_cnt), 16'd0);

    // Handshake stall at acc=5, ext=0; acc moves to 6 during the stall.
    count_in = 4'd5;
    tick(6);
    check_val("stall_acc5", 16'(dut.acc), 16'd5);
    pulse_capture();
    check_val("stall_valid0", 16'(value_valid), 16'd1);
    check_val("stall_value0", 16'(value_out), 16'h05);
    count_in = 4'd6;
    for (int i = 0; i < 6; i++) begin
      capture_req = (i == 4);
      tick();
      check_val($sformatf("stall_value%0d", i + 1), 16'(value_out), 16'h05);
      check_val($sformatf("stall_valid%0d", i + 1), 16'(value_valid), 16'd1);
    end
    capture_req = 1'b0;
    check_val("stall_acc6", 16'(dut.acc), 16'd6);
`ifdef RIPPLE_CAPTURE_OVERRUN_EN
    check_val("ovr_set", 16'(overrun), 16'd1);
`endif

    // Back-to-back capture with ready.
    capture_req = 1'b1;
    value_ready = 1'b1;
    tick();
    capture_req = 1'b0;
    value_ready = 1'b0;
    check_val("b2b_valid", 16'(value_valid), 16'd1);
    check_val("b2b_value", 16'(value_out), 16'h06);
`ifdef RIPPLE_CAPTURE_OVERRUN_EN
    check_val("ovr_clr", 16'(overrun), 16'd0);
`endif
    value_ready = 1'b1;
    tick();
    value_ready = 1'b0;
    check_val("b2b_release", 16'(value_valid), 16'd0);

    // Wrap: 14, 15, 0, each held 4 cycles.
    count_in = 4'd14;
    tick(4);
    count_in = 4'd15;
    tick(4);
    check_val("wrap_none_yet", 16'(wrap_cnt), 16'd0);
    count_in = 4'd0;
    tick(6);
    check_val("wrap_count", 16'(wrap_cnt), 16'd1);
    check_val("wrap_acc", 16'(dut.acc), 16'd0);
    check_val("wrap_ext", 16'(dut.ext), 16'd1);
    pulse_capture();
    check_val("wrap_valid", 16'(value_valid), 16'd1);
    check_val("wrap_value", 16'(value_out), 16'h10);
    value_ready = 1'b1;
    tick();
    value_ready = 1'b0;
    check_val("wrap_release", 16'(value_valid), 16'd0);

    // Reset in HOLD, with a dropped request pending.
    pulse_capture();
    check_val("mid_hold_valid", 16'(value_valid), 16'd1);
    pulse_capture();
`ifdef RIPPLE_CAPTURE_OVERRUN_EN
    check_val("mid_ovr_set", 16'(overrun), 16'd1);
`endif
    ClrN = 1'b0;
    #1;
    check_val("mid_rst_valid", 16'(value_valid), 16'd0);
    check_val("mid_rst_value", 16'(value_out), 16'h00);
    check_val("mid_rst_acc", 16'(dut.acc), 16'd0);
    check_val("mid_rst_ext", 16'(dut.ext), 16'd0);
`ifdef RIPPLE_CAPTURE_OVERRUN_EN
    check_val("mid_rst_ovr", 16'(overrun), 16'd0);
`endif
    tick(2);
    ClrN = 1'b1;
    tick();
    check_val("mid_post_valid", 16'(value_valid), 16'd0);
    check_val("mid_post_wrap", 16'(wrap_pulse), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
